// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the data port of the dual-port BRAM main memory between two
// requesters: requester 0 (CPU load/store unit) and requester 1
// (debug/program loader). Arbitration is round-robin over a valid/ready
// handshake. Only one transaction is in flight at a time, and the memory
// read latency is fixed at one cycle.
//
// Transaction timeline (accept in cycle T):
//   T   IDLE    reqN_ready pulses; the request is latched into mem_* registers
//   T+1 ACCESS  mem_* driven, mem_we = latched we; memory samples at the edge
//   T+2 RESP    reqN_rvalid pulses; rdata = mem_rdata (read) or 0 (write ack)
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid / reqN_ready          request handshake (N = 0, 1)
//   reqN_addr/wdata/be/we            request fields, sampled only at accept
//   reqN_rvalid / reqN_rdata         one-cycle response strobe and data;
//                                    rdata holds its last value otherwise
//   mem_addr/wdata/be/we             to the memory data port
//   mem_rdata                        from memory, one cycle after the address
//
// Optional build macro MEM_ARB_STATS_EN adds:
//   stat_clr                         synchronous clear of all counters
//   stat_grant0, stat_grant1         accepted transactions per requester
//   stat_conflict                    IDLE cycles with both valids and a grant
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MEM_SIZE  = 8192,
  parameter int MEM_WIDTH = 32,
  localparam int AW = $clog2(MEM_SIZE),
  localparam int BW = MEM_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AW-1:0]        req0_addr,
  input  logic [MEM_WIDTH-1:0] req0_wdata,
  input  logic [BW-1:0]        req0_be,
  input  logic                 req0_we,
  output logic                 req0_rvalid,
  output logic [MEM_WIDTH-1:0] req0_rdata,

  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [AW-1:0]        req1_addr,
  input  logic [MEM_WIDTH-1:0] req1_wdata,
  input  logic [BW-1:0]        req1_be,
  input  logic                 req1_we,
  output logic                 req1_rvalid,
  output logic [MEM_WIDTH-1:0] req1_rdata,

  output logic [AW-1:0]        mem_addr,
  output logic [MEM_WIDTH-1:0] mem_wdata,
  output logic [BW-1:0]        mem_be,
  output logic                 mem_we,
  input  logic [MEM_WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [31:0]          stat_grant0,
  output logic [31:0]          stat_grant1,
  output logic [31:0]          stat_conflict
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 rr_pref_q, rr_pref_d;
  logic                 gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [MEM_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]        mem_be_q, mem_be_d;
  logic [MEM_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [MEM_WIDTH-1:0] rdata1_q, rdata1_d;

  // Arbitration decision for the current IDLE cycle.
  logic                 grant_v;
  logic                 grant_id;
  logic [MEM_WIDTH-1:0] resp_data;

  // -------------------------------------------------------------------------
  // Next-state, arbitration and latching
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_pref_d   = rr_pref_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    grant_v     = 1'b0;
    grant_id    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Requester 0 wins when alone or when it holds the preference.
        if (req0_valid && (!req1_valid || !rr_pref_q)) begin
          grant_v  = 1'b1;
          grant_id = 1'b0;
        end else if (req1_valid) begin
          grant_v  = 1'b1;
          grant_id = 1'b1;
        end

        if (grant_v) begin
          gnt_d       = grant_id;
          we_d        = grant_id ? req1_we    : req0_we;
          mem_addr_d  = grant_id ? req1_addr  : req0_addr;
          mem_wdata_d = grant_id ? req1_wdata : req0_wdata;
          mem_be_d    = grant_id ? req1_be    : req0_be;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        rr_pref_d = ~gnt_q;
        state_d   = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Ready is masked by reset because the state register sits in IDLE while
  // reset is held, which would otherwise let a grant show combinationally.
  assign req0_ready = rst_n & grant_v & ~grant_id;
  assign req1_ready = rst_n & grant_v &  grant_id;

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_we    = (state_q == ACCESS) & we_q;

  assign req0_rvalid = (state_q == RESP) & ~gnt_q;
  assign req1_rvalid = (state_q == RESP) &  gnt_q;

  // Writes are acknowledged with zero data.
  assign resp_data = we_q ? '0 : mem_rdata;

  // The response is forwarded combinationally in RESP and captured so that
  // rdata holds its last value afterwards.
  assign req0_rdata = req0_rvalid ? resp_data : rdata0_q;
  assign req1_rdata = req1_rvalid ? resp_data : rdata1_q;

  always_comb begin
    rdata0_d = req0_rdata;
    rdata1_d = req1_rdata;
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_pref_q   <= 1'b0;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_pref_q   <= rr_pref_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Statistics counters (wrap at 2^32; clear wins over increment)
  // -------------------------------------------------------------------------
  logic [31:0] grant0_cnt_q, grant0_cnt_d;
  logic [31:0] grant1_cnt_q, grant1_cnt_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic        inc_grant0, inc_grant1, inc_conflict;

  always_comb begin
    inc_grant0   = rst_n & grant_v & ~grant_id;
    inc_grant1   = rst_n & grant_v &  grant_id;
    inc_conflict = rst_n & grant_v & req0_valid & req1_valid;

    grant0_cnt_d   = grant0_cnt_q   + {31'd0, inc_grant0};
    grant1_cnt_d   = grant1_cnt_q   + {31'd0, inc_grant1};
    conflict_cnt_d = conflict_cnt_q + {31'd0, inc_conflict};

    if (stat_clr) begin
      grant0_cnt_d   = '0;
      grant1_cnt_d   = '0;
      conflict_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant0_cnt_q   <= '0;
      grant1_cnt_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant0_cnt_q   <= grant0_cnt_d;
      grant1_cnt_q   <= grant1_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign stat_grant0   = grant0_cnt_q;
  assign stat_grant1   = grant1_cnt_q;
  assign stat_conflict = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A byte-addressed BRAM model is
// attached to the memory port. Each accepted request is pushed to a
// scoreboard queue together with its due cycle; the response is popped and
// checked against an independent reference byte array that is updated only
// when a transaction completes. Statistics checks are built when
// MEM_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int MEM_SIZE  = 8192;
  localparam int MEM_WIDTH = 32;
  localparam int AW        = 13;
  localparam int BW        = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 req0_valid, req0_ready, req0_we, req0_rvalid;
  logic [AW-1:0]        req0_addr;
  logic [MEM_WIDTH-1:0] req0_wdata, req0_rdata;
  logic [BW-1:0]        req0_be;
  logic                 req1_valid, req1_ready, req1_we, req1_rvalid;
  logic [AW-1:0]        req1_addr;
  logic [MEM_WIDTH-1:0] req1_wdata, req1_rdata;
  logic [BW-1:0]        req1_be;
  logic [AW-1:0]        mem_addr;
  logic [MEM_WIDTH-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0]        mem_be;
  logic                 mem_we;
  logic                 stat_clr;
  logic [31:0]          stat_grant0, stat_grant1, stat_conflict;

  mem_port_arbiter #(
    .MEM_SIZE (MEM_SIZE),
    .MEM_WIDTH(MEM_WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_be    (req0_be),
    .req0_we    (req0_we),
    .req0_rvalid(req0_rvalid),
    .req0_rdata (req0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_be    (req1_be),
    .req1_we    (req1_we),
    .req1_rvalid(req1_rvalid),
    .req1_rdata (req1_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_grant0  (stat_grant0),
    .stat_grant1  (stat_grant1),
    .stat_conflict(stat_conflict)
`endif
  );

`ifndef MEM_ARB_STATS_EN
  assign stat_grant0   = '0;
  assign stat_grant1   = '0;
  assign stat_conflict = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------------
  // Memory: BRAM model on the DUT port and independent reference image
  // ------------------------------------------------------------------------
  logic [7:0] bram    [0:MEM_SIZE-1];
  logic [7:0] ref_mem [0:MEM_SIZE-1];

  always @(posedge clk) begin
    logic [AW-1:0]        a;
    logic [MEM_WIDTH-1:0] rd;
    for (int i = 0; i < 4; i++) begin
      a = mem_addr + AW'(i);
      rd[8*i +: 8] = bram[a];
    end
    mem_rdata <= rd;
    if (mem_we)
      for (int i = 0; i < 4; i++) begin
        a = mem_addr + AW'(i);
        if (mem_be[i]) bram[a] = mem_wdata[8*i +: 8];
      end
  end

  function automatic logic [31:0] ref_read(input logic [AW-1:0] addr);
    logic [31:0]   r;
    logic [AW-1:0] a;
    for (int i = 0; i < 4; i++) begin
      a = addr + AW'(i);
      r[8*i +: 8] = ref_mem[a];
    end
    return r;
  endfunction

  task automatic ref_write(input logic [AW-1:0] addr, input logic [31:0] wd, input logic [3:0] be);
    logic [AW-1:0] a;
    for (int i = 0; i < 4; i++) begin
      a = addr + AW'(i);
      if (be[i]) ref_mem[a] = wd[8*i +: 8];
    end
  endtask

  // ------------------------------------------------------------------------
  // Scoreboard and per-cycle monitor (samples on the falling edge)
  // ------------------------------------------------------------------------
  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          we;
    int            due;
  } item_t;

  item_t exp_q[$];
  int    grant_log[$];
  item_t acc_item;
  int    acc_due = -1;

  always @(negedge clk) begin
    item_t it;
    logic [31:0] exp_data;
    if (!rst_n) begin
      check_eq("rst_ready",  {req0_ready, req1_ready}, 0);
      check_eq("rst_rvalid", {req0_rvalid, req1_rvalid}, 0);
      check_eq("rst_mem_we", mem_we, 0);
    end else begin
      check_eq("ready_excl",  req0_ready & req1_ready, 0);
      check_eq("rvalid_excl", req0_rvalid & req1_rvalid, 0);
      check_eq("ready_no_valid", (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid), 0);

      if (acc_due == cyc) begin
        check_eq("acc_addr", mem_addr, acc_item.addr);
        check_eq("acc_be",   mem_be,   acc_item.be);
        check_eq("acc_we",   mem_we,   acc_item.we);
        if (acc_item.we) check_eq("acc_wdata", mem_wdata, acc_item.wdata);
        acc_due = -1;
      end else begin
        check_eq("mem_we_idle", mem_we, 0);
      end

      if (req0_rvalid || req1_rvalid) begin
        if (exp_q.size() == 0) begin
          check_eq("rv_spurious", 1, 0);
        end else begin
          it = exp_q.pop_front();
          exp_data = it.we ? 32'h0 : ref_read(it.addr);
          if (it.we) ref_write(it.addr, it.wdata, it.be);
          check_eq("rv_id",      {63'd0, req1_rvalid}, it.id);
          check_eq("rv_latency", cyc, it.due);
          check_eq("rv_rdata", req1_rvalid ? req1_rdata : req0_rdata, exp_data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check_eq("rv_missing", 0, 1);
        void'(exp_q.pop_front());
      end

      if (req0_ready || req1_ready) begin
        it.id    = req1_ready ? 1 : 0;
        it.addr  = req1_ready ? req1_addr  : req0_addr;
        it.wdata = req1_ready ? req1_wdata : req0_wdata;
        it.be    = req1_ready ? req1_be    : req0_be;
        it.we    = req1_ready ? req1_we    : req0_we;
        it.due   = cyc + 2;
        exp_q.push_back(it);
        acc_item = it;
        acc_due  = cyc + 1;
        grant_log.push_back(it.id);
      end
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------------
  task automatic drive(input int id, input logic v, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [3:0] be, input logic we);
    if (id == 0) begin
      req0_valid = v; req0_addr = a; req0_wdata = wd; req0_be = be; req0_we = we;
    end else begin
      req1_valid = v; req1_addr = a; req1_wdata = wd; req1_be = be; req1_we = we;
    end
  endtask

  task automatic wait_grants(input int target);
    int n = 0;
    while (grant_log.size() < target && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (grant_log.size() < target) check_eq("grant_timeout", grant_log.size(), target);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) check_eq("done_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic issue(input int id, input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic we);
    @(posedge clk); #1;
    drive(id, 1'b1, a, wd, be, we);
    wait_grants(grant_log.size() + 1);
    @(posedge clk); #1;
    drive(id, 1'b0, '0, '0, '0, 1'b0);
    wait_done();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_due = -1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ------------------------------------------------------------------------
  // Test sequence
  // ------------------------------------------------------------------------
  initial begin
    int n;
    rst_n    = 1'b0;
    stat_clr = 1'b0;
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < MEM_SIZE; i++) begin
      bram[i]    = 8'(i) ^ 8'h5C;
      ref_mem[i] = 8'(i) ^ 8'h5C;
    end
    bram[16] = 8'hEF; bram[17] = 8'hBE; bram[18] = 8'hAD; bram[19] = 8'hDE;
    ref_mem[16] = 8'hEF; ref_mem[17] = 8'hBE; ref_mem[18] = 8'hAD; ref_mem[19] = 8'hDE;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_rdata0", req0_rdata, 0);
    check_eq("reset_mem_addr", {mem_addr, mem_be, mem_wdata}, 0);
    rst_n = 1'b1;

    // Basic read from requester 0.
    issue(0, 13'h10, 32'h0, 4'hF, 1'b0);
    check_eq("read_deadbeef_hold", req0_rdata, 32'hDEADBEEF);

    // Partial write from requester 1, then read back.
    issue(1, 13'h6, 32'hA5A5A5A5, 4'b0011, 1'b1);
    check_eq("write_ack_hold", req1_rdata, 0);
    check_eq("other_rdata_hold", req0_rdata, 32'hDEADBEEF);
    issue(1, 13'h6, 32'h0, 4'hF, 1'b0);
    check_eq("readback_low", req1_rdata[15:0], 16'hA5A5);

    // Write with no byte enables leaves memory unchanged but is acknowledged.
    issue(0, 13'h6, 32'h12345678, 4'b0000, 1'b1);
    check_eq("be0_ack", req0_rdata, 0);
    issue(0, 13'h6, 32'h0, 4'hF, 1'b0);
    check_eq("be0_unchanged", req0_rdata[15:0], 16'hA5A5);

    // Unaligned read near the top of memory wraps the byte address.
    issue(1, 13'h1FFE, 32'h0, 4'hF, 1'b0);

    // Continuous contention from reset: grants alternate.
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_due = -1;
    grant_log.delete();
    drive(0, 1'b1, 13'h10, 32'h0, 4'hF, 1'b0);
    drive(1, 1'b1, 13'h6, 32'h0, 4'hF, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_grants(6);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    wait_done();
    for (int i = 0; i < 6; i++)
      if (i < grant_log.size()) check_eq($sformatf("rr_order_%0d", i), grant_log[i], i % 2);

    // Reset asserted during the ACCESS cycle of a requester 0 write.
    grant_log.delete();
    @(posedge clk); #1;
    drive(0, 1'b1, 13'h20, 32'hCAFEF00D, 4'hF, 1'b1);
    wait_grants(1);
    @(posedge clk); #1;
    check_eq("access_we_pre_reset", mem_we, 1);
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    acc_due = -1;
    #1;
    check_eq("reset_kills_we", mem_we, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    grant_log.delete();
    drive(0, 1'b1, 13'h20, 32'h0, 4'hF, 1'b0);
    drive(1, 1'b1, 13'h20, 32'h0, 4'hF, 1'b0);
    wait_grants(1);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    wait_done();
    if (grant_log.size() > 0) check_eq("pref_after_reset", grant_log[0], 0);

    // Requester 0 pulses valid only during RESP: it must be ignored.
    @(posedge clk); #1;
    drive(1, 1'b1, 13'h10, 32'h0, 4'hF, 1'b0);
    n = grant_log.size();
    wait_grants(n + 1);
    @(posedge clk); #1;
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 13'h30, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    check_eq("pulse_no_ready", req0_ready, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    n = grant_log.size();
    repeat (4) @(negedge clk);
    #1;
    check_eq("pulse_no_grant", grant_log.size(), n);
    check_eq("pulse_no_access", mem_addr, 13'h10);
    check_eq("pulse_no_resp", exp_q.size(), 0);

`ifdef MEM_ARB_STATS_EN
    // Statistics: two contended grants, then requester 0 alone.
    apply_reset();
    grant_log.delete();
    check_eq("stat_reset", {stat_grant0, stat_grant1}, 0);
    drive(0, 1'b1, 13'h40, 32'h0, 4'hF, 1'b0);
    drive(1, 1'b1, 13'h44, 32'h0, 4'hF, 1'b0);
    wait_grants(2);
    @(posedge clk); #1;
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    wait_grants(5);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    wait_done();
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) check_eq($sformatf("stat_order_%0d", i), grant_log[i], (i == 1) ? 1 : 0);
    check_eq("stat_grant0", stat_grant0, 4);
    check_eq("stat_grant1", stat_grant1, 1);
    check_eq("stat_conflict", stat_conflict, 2);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check_eq("stat_clr", {stat_grant0, stat_grant1} | {32'd0, stat_conflict}, 0);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1);
  end

endmodule
